// File: rtl/shift_pkg.sv
// Shared constants for the shift-share arbiter: op codes, output-stage state encoding
// and default datapath widths.
package shift_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/shift_unit_core.sv
// Combinational shifter: SLL, SRL, SRA and op 11 (rotate-left when SHIFT_ARB_ROTATE_EN
// is defined, otherwise reserved and returning zero).
module shift_unit_core
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [1:0]         op_i,
  output logic [DATA_W-1:0]  result_o
);

  // Op decode; a shift by DATA_W in the rotate term yields zero, so shamt=0 rotates cleanly.
  always_comb begin
    case (op_i)
      OP_SLL:  result_o = data_i << shamt_i;
      OP_SRL:  result_o = data_i >> shamt_i;
      OP_SRA:  result_o = DATA_W'($signed(data_i) >>> shamt_i);
`ifdef SHIFT_ARB_ROTATE_EN
      OP_ROL:  result_o = (data_i << shamt_i) | (data_i >> (DATA_W - int'(shamt_i)));
`else
      OP_ROL:  result_o = '0;
`endif
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/shift_share_arbiter.sv
// Round-robin arbiter sharing one shift_unit_core among NUM_REQ requesters, with a
// single-entry registered result stage. Optional macro: SHIFT_ARB_ROTATE_EN.
module shift_share_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int ID_W    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0]   req_shamt,
  input  logic [NUM_REQ*2-1:0]         req_op,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [ID_W-1:0]              rsp_id
);

  localparam logic [ID_W:0]   NUM_REQ_L = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  logic [0:0]         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] rot_s;
  logic [ID_W-1:0]    pos_s, gnt_s;
  logic [ID_W:0]      sum_s;
  logic               found_s, can_accept_s, xfer_s;
  logic [DATA_W-1:0]  sel_data_s, result_s;
  logic [SHAMT_W-1:0] sel_shamt_s;
  logic [1:0]         sel_op_s;

  // Rotate valids so rr_ptr sits at bit 0, pick the lowest set bit, then map back.
  always_comb begin
    rot_s = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
    pos_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos_s = rot_s[k] ? ID_W'(k) : pos_s;
    end
    found_s = |rot_s;
    sum_s   = {1'b0, rr_ptr_q} + {1'b0, pos_s};
    gnt_s   = (sum_s >= NUM_REQ_L) ? ID_W'(sum_s - NUM_REQ_L) : ID_W'(sum_s);
  end

  assign can_accept_s = (state_q == ST_EMPTY) | (rsp_valid & rsp_ready);
  // rst_n gating keeps req_ready low while the block is held in reset.
  assign xfer_s       = found_s & can_accept_s & rst_n;
  assign req_ready    = xfer_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_s) : '0;

  assign sel_data_s  = req_data[int'(gnt_s)*DATA_W +: DATA_W];
  assign sel_shamt_s = req_shamt[int'(gnt_s)*SHAMT_W +: SHAMT_W];
  assign sel_op_s    = req_op[int'(gnt_s)*2 +: 2];

  shift_unit_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .data_i   (sel_data_s),
    .shamt_i  (sel_shamt_s),
    .op_i     (sel_op_s),
    .result_o (result_s)
  );

  // Next state: a transfer wins over a plain drain so back-to-back ops leave no bubble.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (xfer_s) begin
      state_d    = ST_FULL;
      rsp_data_d = result_s;
      rsp_id_d   = gnt_s;
      rr_ptr_d   = (gnt_s == LAST_ID) ? '0 : gnt_s + ID_W'(1);
    end else if (rsp_valid && rsp_ready) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_share_arbiter.sv
// Scoreboard bench for shift_share_arbiter; honours SHIFT_ARB_ROTATE_EN for op 11.
module tb_shift_share_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_data;
  logic [N*5-1:0] req_shamt;
  logic [N*2-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [31:0]    rsp_data;
  logic [1:0]     rsp_id;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb_q[$];
  logic xfer_prev = 1'b0;

  shift_share_arbiter #(.NUM_REQ(N), .DATA_W(32), .SHAMT_W(5), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-by-bit reference shifter.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] op);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) begin
      case (op)
        2'b00:   r[b] = (b >= sh) ? d[b-sh] : 1'b0;
        2'b01:   r[b] = (b + sh < 32) ? d[b+sh] : 1'b0;
        2'b10:   r[b] = (b + sh < 32) ? d[b+sh] : d[31];
`ifdef SHIFT_ARB_ROTATE_EN
        default: r[b] = d[(b - sh + 32) % 32];
`else
        default: r[b] = 1'b0;
`endif
      endcase
    end
    return r;
  endfunction

  // Scoreboard monitor: pop on response handshake, push on request handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      xfer_prev = 1'b0;
    end else begin
      rsp_t e;
      if (xfer_prev) check_eq("latency", rsp_valid, 1);
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_rsp_data", rsp_data, e.data);
          check_eq("sb_rsp_id", rsp_id, e.id);
        end
      end
      check_eq("ready_onehot", ($countones(req_ready) <= 1), 1);
      xfer_prev = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id   = 2'(i);
          e.data = ref_shift(req_data[i*32 +: 32], int'(req_shamt[i*5 +: 5]), req_op[i*2 +: 2]);
          sb_q.push_back(e);
          xfer_prev = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input int sh, input logic [1:0] op);
    req_data[i*32 +: 32] = d;
    req_shamt[i*5 +: 5]  = 5'(sh);
    req_op[i*2 +: 2]     = op;
  endtask

  task automatic issue(input int i, input logic [31:0] d, input int sh, input logic [1:0] op,
                       input logic [31:0] exp, input string tag);
    set_req(i, d, sh, op);
    req_valid[i] = 1'b1;
    #1;
    for (int c = 0; c < 20 && !req_ready[i]; c++) tick();
    check_eq({tag, "_grant"}, req_ready[i], 1);
    tick();
    req_valid[i] = 1'b0;
    check_eq(tag, rsp_data, exp);
    check_eq({tag, "_id"}, rsp_id, i);
  endtask

  logic [31:0] hold_data;

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_shamt = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    req_valid[0] = 1'b1;
    #2;
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_req_ready", req_ready, 0);
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;

    issue(0, 32'h0000_0001, 4, 2'b00, 32'h0000_0010, "sll_basic");
    issue(1, 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF, "sra31");
    issue(2, 32'h8000_0000, 31, 2'b01, 32'h0000_0001, "srl31");
    issue(3, 32'h8000_0000, 31, 2'b00, 32'h0000_0000, "sll31");
    issue(0, 32'hDEAD_BEEF, 0, 2'b10, 32'hDEAD_BEEF, "sra_sh0");
    issue(1, 32'hDEAD_BEEF, 0, 2'b00, 32'hDEAD_BEEF, "sll_sh0");
    issue(2, 32'h1234_5678, 8, 2'b01, 32'h0012_3456, "srl8");
    issue(0, 32'h7FFF_FFFF, 4, 2'b10, 32'h07FF_FFFF, "sra_pos");
`ifdef SHIFT_ARB_ROTATE_EN
    issue(3, 32'h8000_0001, 1, 2'b11, 32'h0000_0003, "op11");
`else
    issue(3, 32'h8000_0001, 1, 2'b11, 32'h0000_0000, "op11");
`endif
    tick();
    tick();

    // Round robin from a fresh pointer with everyone requesting.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_req(i, $urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    end
    req_valid = '1;
    #1;
    for (int c = 0; c < 8; c++) begin
      check_eq("rr_grant", req_ready, 32'(1) << (c % N));
      if (c > 0) check_eq("rr_no_bubble", rsp_valid, 1);
      tick();
      set_req(c % N, $urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      #1;
    end
    req_valid = '0;
    tick();
    tick();

    // Backpressure with a second requester waiting.
    rsp_ready = 1'b0;
    issue(2, 32'hCAFE_F00D, 4, 2'b01, 32'h0CAF_EF00, "bp_first");
    hold_data = rsp_data;
    set_req(3, 32'h0000_00FF, 8, 2'b00);
    req_valid[3] = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      check_eq("bp_ready", req_ready, 0);
      check_eq("bp_valid", rsp_valid, 1);
      check_eq("bp_data", rsp_data, hold_data);
      check_eq("bp_id", rsp_id, 2);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_release_grant", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    check_eq("bp_next_valid", rsp_valid, 1);
    check_eq("bp_next_data", rsp_data, 32'h0000_FF00);
    check_eq("bp_next_id", rsp_id, 3);

    // Reset while holding a result with the pointer parked at 2.
    issue(1, 32'h0000_0001, 1, 2'b00, 32'h0000_0002, "pre_rst");
    rsp_ready = 1'b0;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    #1;
    check_eq("pre_rst_stall", req_ready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", rsp_valid, 0);
    check_eq("mid_rst_data", rsp_data, 0);
    check_eq("mid_rst_ready", req_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_valid", rsp_valid, 0);
    check_eq("post_rst_grant", req_ready, 4'b0010);
    rsp_ready = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    check_eq("post_rst_id", rsp_id, 1);
    #1;
    check_eq("post_rst_next", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    tick();
    check_eq("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_share_arbiter.md
Name: shift_share_arbiter

Overview:
- Shares one 32-bit shift datapath (logical left, logical right, arithmetic right) between NUM_REQ requesters.
- Each requester uses a valid/ready request port. One response port is tagged with the requester ID.
- Round-robin grant; a single-entry registered result stage supports back-to-back throughput of one op per cycle.
- Sits between the ALU-side issue logic and the shared shift unit in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width (log2 DATA_W).
- ID_W, 2, requester-ID width (clog2 NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_data  in  NUM_REQ*DATA_W  packed operands; requester i at [i*DATA_W +: DATA_W].
- req_shamt  in  NUM_REQ*SHAMT_W  packed shift amounts.
- req_op  in  NUM_REQ*2  packed op codes: 00 SLL, 01 SRL, 10 SRA, 11 ROL/reserved.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  DATA_W  shifted result.
- rsp_id  out  ID_W  requester that issued the result.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0.
  - Round-robin pointer rr_ptr=0.
  - FSM=EMPTY.
- FSM states:
  - EMPTY: output register holds nothing.
  - FULL: output register holds a result.
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Grant (combinational):
  - First requester with req_valid set, searching circularly from rr_ptr.
  - req_ready[g]=1 only if can_accept and a requester is found; all other bits 0.
  - req_ready never depends on its own req_valid beyond selection; no combinational path from rsp_ready to rsp_data.
- Transfer: req_valid[g] & req_ready[g]. On transfer:
  - Result is computed from the granted operands and registered into rsp_data.
  - rsp_id<=g, rsp_valid<=1, state<=FULL.
  - rr_ptr<=(g+1) mod NUM_REQ.
- Latency: exactly 1 cycle from accept to rsp_valid.
- Drain without new grant: rsp_valid&rsp_ready and no transfer -> rsp_valid<=0, state<=EMPTY.
- Simultaneous drain and transfer: new result overwrites; rsp_valid stays 1, no bubble. Sustained throughput is 1 op/cycle.
- Backpressure: in FULL with rsp_ready=0, rsp_data/rsp_id/rsp_valid are held stable and all req_ready=0.
- Arithmetic:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA replicates data[DATA_W-1].
  - shamt=0 returns the operand unchanged; shamt=31 is the maximum shift.
- rr_ptr wraps from NUM_REQ-1 to 0. rr_ptr is unchanged when no transfer occurs.
- Fairness: a requester holding req_valid is granted within NUM_REQ transfers.
- Requesters must hold valid, data, shamt and op stable until accepted; the arbiter does not latch unaccepted requests.
- Reset asserted mid-operation drops any held result immediately; no response is emitted after reset release.

Optional Feature:
- Macro: SHIFT_ARB_ROTATE_EN.
- Defined: op 11 = rotate left by shamt; bits shifted out of the MSB re-enter at the LSB.
- Undefined: op 11 is reserved; the request is accepted and returns rsp_data=0 with the normal rsp_id and latency.

Decomposition:
- Shared package shift_pkg:
  - Op-code localparams OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROL=2'b11.
  - State encoding ST_EMPTY/ST_FULL.
  - DATA_W/SHAMT_W defaults.
- One sub-module: shift_unit_core, combinational (operand, shamt, op) -> result, covering all four ops.
- The arbiter instantiates shift_unit_core once after the grant mux.

Test Plan:
- Reset, then a single request: req0 data=0x0000_0001, shamt=4, op=SLL -> next cycle rsp_valid=1, rsp_data=0x0000_0010, rsp_id=0.
- Arithmetic ops: SRA of 0x8000_0000 by 31 -> 0xFFFF_FFFF; SRL of the same -> 0x0000_0001; shamt=0 -> operand unchanged.
- All 4 requesters valid, rsp_ready=1 held -> grants in order 0,1,2,3,0 on consecutive cycles, one rsp per cycle, no bubbles.
- Backpressure: rsp_ready=0 for 3 cycles with FULL -> rsp_data/rsp_id stable and req_ready=0; on release, the next grant goes in the same cycle as the drain.
- Reset mid-operation: rst_n low while FULL -> rsp_valid=0 immediately and rr_ptr=0; the first grant after release goes to the lowest valid index.
- Op 11, data=0x8000_0001, shamt=1: with SHIFT_ARB_ROTATE_EN -> 0x0000_0003; without -> 0x0000_0000.
